// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - SDRAM controller request/return port shared by mem_arbiter
interface mem_arbiter_if;
    logic [23:0] addr;
    logic [15:0] data;
    logic        req;
    logic        wr;
    logic        ack;
    logic [15:0] mem;
    logic        valid;

    // mem is broadcast straight to the requesters, so the arbiter never reads it
    modport master (output addr, data, req, wr, input ack, valid);
    modport slave  (input addr, data, req, wr, output ack, mem, valid);
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin SDRAM request arbiter with read-burst steering via an ID FIFO
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest eligible index wins).
module mem_arbiter #(
    parameter int NREQ  = 4,
    parameter int BURST = 8,
    parameter int DEPTH = 4
) (
    input  logic               clkSYS,
    input  logic               n_reset,
    input  logic [NREQ*24-1:0] r_addr,
    input  logic [NREQ*16-1:0] r_data,
    input  logic [NREQ-1:0]    r_req,
    input  logic [NREQ-1:0]    r_wr,
    output logic [NREQ-1:0]    r_ack,
    output logic [NREQ-1:0]    r_valid,
    output logic [2:0]         gnt_id,
    output logic               err,
    mem_arbiter_if.master      ctrl
);
    localparam int BW = $clog2(BURST) + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [2:0]    gnt_id_q, gnt_id_d, win;
    logic [2:0]    fifo_q [DEPTH];
    logic [2:0]    fifo_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          err_q, err_d;
    logic [NREQ-1:0] elig;
    logic          fifo_empty, fifo_full, push, pop, last_beat;
    int            gi, hi;

    assign gi         = int'(gnt_id_q);
    assign hi         = int'(fifo_q[rptr_q]);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(DEPTH));
    assign last_beat  = (beat_q == BW'(BURST - 1));
    assign push       = (state_q == S_GRANT) && ctrl.ack && !r_wr[gi];
    assign pop        = ctrl.valid && !fifo_empty && last_beat;
    assign gnt_id     = gnt_id_q;
    assign err        = err_q;

    // Reads wait while no ID slot is free; writes never produce a return burst
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++)
            elig[i] = r_req[i] && (r_wr[i] || !fifo_full);
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        win = gnt_id_q;
        for (int i = NREQ - 1; i >= 0; i--)
            if (elig[i]) win = 3'(i);
    end
`else
    logic found;

    always_comb begin
        found = 1'b0;
        win   = gnt_id_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && elig[(gi + k) % NREQ]) begin
                win   = 3'((gi + k) % NREQ);
                found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|elig) state_d = S_GRANT;
            S_GRANT: if (ctrl.ack) state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl.req  = 1'b0;
        ctrl.wr   = 1'b0;
        ctrl.addr = '0;
        ctrl.data = '0;
        r_ack     = '0;
        r_valid   = '0;
        if (state_q == S_GRANT) begin
            ctrl.req  = 1'b1;
            ctrl.wr   = r_wr[gi];
            ctrl.addr = r_addr[gi*24 +: 24];
            ctrl.data = r_data[gi*16 +: 16];
            r_ack[gi] = ctrl.ack;
        end
        if (ctrl.valid && !fifo_empty) r_valid[hi] = 1'b1;
    end

    always_comb begin
        gnt_id_d = gnt_id_q;
        fifo_d   = fifo_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        err_d    = err_q;
        if (state_q == S_IDLE && |elig) gnt_id_d = win;
        // When full, push and pop share a slot: the head is consumed this cycle before the write lands
        if (push) begin
            fifo_d[wptr_q] = gnt_id_q;
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (ctrl.valid) begin
            if (fifo_empty) err_d = 1'b1;
            else            beat_d = last_beat ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            gnt_id_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            gnt_id_q <= gnt_id_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            fifo_q   <= fifo_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int NREQ = 4;

    logic               clkSYS = 1'b0;
    logic               n_reset;
    logic [NREQ*24-1:0] r_addr;
    logic [NREQ*16-1:0] r_data;
    logic [NREQ-1:0]    r_req, r_wr, r_ack, r_valid;
    logic [2:0]         gnt_id;
    logic               err;
    int                 n_assert = 0;
    int                 n_fail   = 0;

`ifdef MEM_ARB_FIXED_PRIO_EN
    int rr_exp [5] = '{0, 0, 0, 0, 0};
`else
    int rr_exp [5] = '{3, 0, 1, 2, 3};
`endif

    mem_arbiter_if ctrl ();

    mem_arbiter #(.NREQ(4), .BURST(8), .DEPTH(4)) dut (
        .clkSYS  (clkSYS),
        .n_reset (n_reset),
        .r_addr  (r_addr),
        .r_data  (r_data),
        .r_req   (r_req),
        .r_wr    (r_wr),
        .r_ack   (r_ack),
        .r_valid (r_valid),
        .gnt_id  (gnt_id),
        .err     (err),
        .ctrl    (ctrl)
    );

    always #5 clkSYS = ~clkSYS;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkSYS);
        #2;
    endtask

    task automatic beats(input logic [3:0] exp, input int n, input string tag);
        for (int b = 0; b < n; b++) begin
            ctrl.valid = 1'b1;
            ctrl.mem   = 16'(b);
            #1 chk(tag, r_valid, exp);
            tick();
        end
        ctrl.valid = 1'b0;
    endtask

    task automatic read_req(input int i);
        r_req[i] = 1'b1;
        r_wr[i]  = 1'b0;
        tick();
        ctrl.ack = 1'b1;
        #1 chk("rd_gnt", gnt_id, 32'(i));
        chk("rd_ack", r_ack, 32'(1 << i));
        tick();
        ctrl.ack = 1'b0;
        r_req[i] = 1'b0;
        tick();
    endtask

    initial begin
        n_reset    = 1'b0;
        r_addr     = '0;
        r_data     = '0;
        r_req      = '0;
        r_wr       = '0;
        ctrl.ack   = 1'b0;
        ctrl.mem   = '0;
        ctrl.valid = 1'b0;

        tick();
        chk("rst_req", ctrl.req, 0);
        chk("rst_wr", ctrl.wr, 0);
        chk("rst_addr", ctrl.addr, 0);
        chk("rst_data", ctrl.data, 0);
        chk("rst_r_ack", r_ack, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_err", err, 0);
        n_reset = 1'b1;
        tick();

        // single write from requester 2, controller acks two cycles after req
        r_req[2] = 1'b1;
        r_wr[2]  = 1'b1;
        r_addr[48 +: 24] = 24'h000123;
        r_data[32 +: 16] = 16'hBEEF;
        #1 chk("sw_req_idle", ctrl.req, 0);
        tick();
        chk("sw_req", ctrl.req, 1);
        chk("sw_gnt", gnt_id, 2);
        chk("sw_addr", ctrl.addr, 24'h000123);
        chk("sw_data", ctrl.data, 16'hBEEF);
        chk("sw_wr", ctrl.wr, 1);
        chk("sw_ack_early", r_ack, 0);
        tick();
        chk("sw_req_wait", ctrl.req, 1);
        tick();
        ctrl.ack = 1'b1;
        #1 chk("sw_r_ack", r_ack, 4'b0100);
        tick();
        ctrl.ack = 1'b0;
        r_req[2] = 1'b0;
        #1 chk("sw_hold_req", ctrl.req, 0);
        chk("sw_r_ack_off", r_ack, 0);
        tick();

        // all four requesters writing, acked immediately
        r_wr  = 4'hF;
        r_req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            tick();
            ctrl.ack = 1'b1;
            #1 chk("rr_req", ctrl.req, 1);
            chk("rr_gnt", gnt_id, 32'(rr_exp[n]));
            chk("rr_ack", r_ack, 32'(1 << rr_exp[n]));
            tick();
            ctrl.ack = 1'b0;
            #1 chk("rr_hold_req", ctrl.req, 0);
            tick();
            if (n == 4) r_req = '0;
            #1 chk("rr_idle_req", ctrl.req, 0);
        end
        r_wr = '0;

        // read steering: requester 1 then 3, 16 beats
        read_req(1);
        read_req(3);
        beats(4'b0010, 8, "steer_r1");
        beats(4'b1000, 8, "steer_r3");
        #1 chk("steer_err", err, 0);

        // fill the ID FIFO, then a read is blocked while a write proceeds
        read_req(0);
        read_req(1);
        read_req(2);
        read_req(0);
        r_req[1] = 1'b1;
        r_wr[1]  = 1'b0;
        r_req[3] = 1'b1;
        r_wr[3]  = 1'b1;
        tick();
        ctrl.ack = 1'b1;
        #1 chk("full_gnt", gnt_id, 3);
        chk("full_wr", ctrl.wr, 1);
        chk("full_ack", r_ack, 4'b1000);
        tick();
        ctrl.ack = 1'b0;
        r_req[3] = 1'b0;
        #1 chk("full_hold", ctrl.req, 0);
        tick();
        chk("full_block", ctrl.req, 0);
        for (int b = 0; b < 8; b++) begin
            ctrl.valid = 1'b1;
            #1 chk("full_beat", r_valid, 4'b0001);
            chk("full_block_beat", ctrl.req, 0);
            tick();
        end
        ctrl.valid = 1'b0;
        #1 chk("pop_cycle_req", ctrl.req, 0);
        tick();
        chk("unblk_req", ctrl.req, 1);
        chk("unblk_gnt", gnt_id, 1);
        chk("unblk_wr", ctrl.wr, 0);
        ctrl.ack = 1'b1;
        #1 chk("unblk_ack", r_ack, 4'b0010);
        tick();
        ctrl.ack = 1'b0;
        r_req[1] = 1'b0;
        tick();
        beats(4'b0010, 8, "drain_r1");
        beats(4'b0100, 8, "drain_r2");
        beats(4'b0001, 8, "drain_r0");

        // read ack lands on the last beat of the only outstanding burst
        r_req[2] = 1'b1;
        r_wr[2]  = 1'b0;
        for (int b = 0; b < 8; b++) begin
            ctrl.valid = 1'b1;
            if (b == 7) ctrl.ack = 1'b1;
            #1 chk("pp_beat", r_valid, 4'b0010);
            if (b == 1) chk("pp_gnt", gnt_id, 2);
            if (b == 7) chk("pp_ack", r_ack, 4'b0100);
            tick();
        end
        ctrl.valid = 1'b0;
        ctrl.ack   = 1'b0;
        r_req[2]   = 1'b0;
        tick();
        beats(4'b0100, 8, "pp_new_id");

        // stray beat with the FIFO empty
        #1 chk("stray_err_pre", err, 0);
        ctrl.valid = 1'b1;
        #1 chk("stray_r_valid", r_valid, 0);
        tick();
        ctrl.valid = 1'b0;
        #1 chk("stray_err", err, 1);

        // asynchronous reset in the middle of a grant
        r_req[0] = 1'b1;
        r_wr[0]  = 1'b1;
        r_addr[0 +: 24] = 24'hABCDEF;
        r_data[0 +: 16] = 16'h1234;
        tick();
        ctrl.ack = 1'b1;
        #1 chk("mid_req", ctrl.req, 1);
        chk("mid_addr", ctrl.addr, 24'hABCDEF);
        chk("mid_ack", r_ack, 4'b0001);
        n_reset = 1'b0;
        #1 chk("arst_req", ctrl.req, 0);
        chk("arst_wr", ctrl.wr, 0);
        chk("arst_addr", ctrl.addr, 0);
        chk("arst_data", ctrl.data, 0);
        chk("arst_r_ack", r_ack, 0);
        chk("arst_r_valid", r_valid, 0);
        chk("arst_gnt", gnt_id, 0);
        chk("arst_err", err, 0);
        ctrl.ack = 1'b0;
        r_req    = '0;
        tick();
        n_reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
